// File: rtl/dram_arbiter_pkg.sv
// Purpose: shared types and defaults for the two-port data-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_arbiter_pkg;

    // Last winner of the RAM port; IDLE means nobody requested last cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Pending read return: which port gets the RAM data next cycle.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_ret_t;

    localparam int MAX_LOCK_DEF = 16;

endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// Purpose: combinational 2-way round-robin selector with a port-1 override.
// Latency: 0 cycles (pure combinational).
// Backpressure: a losing requester simply sees gnt=0 and keeps requesting.
// Ports: req[1:0] requests, last = index of previous winner (port 1 when idle,
//        so port 0 goes first), force1 = port 1 wins a tie, gnt[1:0] one-hot.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                // On a tie the port that did not win last goes, unless port 1 holds a lock.
                if (force1 || !last) gnt = 2'b10;
                else                 gnt = 2'b01;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// Purpose: shares a single-port data RAM between CPU bus (port 0) and a second master (port 1).
// Latency: grant 0 cycles uncontended; read data/rvalid 1 cycle after grant.
// Backpressure: losers see gnt=0 and hold their request; port 1 lock bounded by MAX_LOCK.
// Ports: m*_req/we/addr/wdata in, m*_gnt out (comb), m*_rvalid/rdata out, m1_lock in,
//        ram_addr/ram_dina/ram_wea to RAM, ram_douta from RAM, lock_abort pulse out.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  m0_req,
    input  logic [DATA_W/8-1:0]   m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic                  m1_req,
    input  logic [DATA_W/8-1:0]   m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic                  m1_lock,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_dina,
    output logic [DATA_W/8-1:0]   ram_wea,
    input  logic [DATA_W-1:0]     ram_douta,
    output logic                  lock_abort
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LCNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK);

    arb_state_t        state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    rd_ret_t           rd_ret_q, rd_ret_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dina_q;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       last;
    logic       force1;

    // Reset masks requests so nothing is granted (and nothing written) while rstn is low.
    assign req    = {m1_req & rstn, m0_req & rstn};
    assign last   = (state_q != OWN0);
    assign force1 = (state_q == OWN1) && m1_lock && (lcnt_q < LCNT_MAX);

    rr_pick2 u_pick (
        .req    (req),
        .last   (last),
        .force1 (force1),
        .gnt    (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_comb begin
        state_d  = IDLE;
        lcnt_d   = lcnt_q;
        abort_d  = 1'b0;
        rd_ret_d = '0;
        ram_addr = addr_q;
        ram_dina = dina_q;
        ram_wea  = '0;

        if (gnt[0]) begin
            state_d  = OWN0;
            ram_addr = m0_addr;
            ram_dina = m0_wdata;
            ram_wea  = m0_we;
            rd_ret_d = '{valid: (m0_we == '0), port: 1'b0};
        end else if (gnt[1]) begin
            state_d  = OWN1;
            ram_addr = m1_addr;
            ram_dina = m1_wdata;
            ram_wea  = m1_we;
            rd_ret_d = '{valid: (m1_we == '0), port: 1'b1};
        end

        // lcnt measures how long port 0 has been starved by a port-1 lock;
        // it restarts whenever port 0 is served or stops waiting.
        if (gnt[0] || !m1_lock || !m0_req || state_d == IDLE) begin
            lcnt_d = '0;
        end else if (gnt[1] && lcnt_q != LCNT_MAX) begin
            lcnt_d = lcnt_q + 1'b1;
        end

        abort_d = gnt[0] && m1_lock && (lcnt_q == LCNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            lcnt_q   <= '0;
            rd_ret_q <= '0;
            abort_q  <= 1'b0;
            addr_q   <= '0;
            dina_q   <= '0;
        end else begin
            state_q  <= state_d;
            lcnt_q   <= lcnt_d;
            rd_ret_q <= rd_ret_d;
            abort_q  <= abort_d;
            addr_q   <= ram_addr;
            dina_q   <= ram_dina;
        end
    end

    // Only one grant per cycle, so a single return slot steers RAM data to the right port.
    assign m0_rvalid  = rd_ret_q.valid && !rd_ret_q.port;
    assign m1_rvalid  = rd_ret_q.valid &&  rd_ret_q.port;
    assign m0_rdata   = ram_douta;
    assign m1_rdata   = ram_douta;
    assign lock_abort = abort_q;

    if (BE_W * 8 != DATA_W) begin : g_bad_width
        $error("DATA_W must be a multiple of 8");
    end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

    logic        clk;
    logic        rstn;
    logic        m0_req, m1_req, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lock_abort;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_dina, ram_douta;
    logic [3:0]  ram_wea;

    int errors = 0;
    int checks = 0;

    dram_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(16)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_douta(ram_douta), .lock_abort(lock_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: byte write enables, one-cycle read latency.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) mem[ram_addr][8*b +: 8] <= ram_dina[8*b +: 8];
        ram_douta <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        m0_req;
        logic [3:0]  m0_we;
        logic [9:0]  m0_addr;
        logic        m1_req;
        logic [3:0]  m1_we;
        logic [9:0]  m1_addr;
        logic [31:0] m1_wdata;
        logic        m1_lock;
        logic        e_g0;
        logic        e_g1;
        logic        e_rv0;
        logic        e_rv1;
        logic [3:0]  e_wea;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    endtask

    initial begin
        int n_m1;
        logic got;

        // Solo read, alternating contention, byte write then readback.
        vecs[0] = '{1, 4'h0, 10'h005, 0, 4'h0, 10'h000, 32'h0, 0,  1, 0, 0, 0, 4'h0, 32'h0};
        vecs[1] = '{0, 4'h0, 10'h000, 0, 4'h0, 10'h000, 32'h0, 0,  0, 0, 1, 0, 4'h0, 32'hDEADBEEF};
        vecs[2] = '{1, 4'h0, 10'h007, 1, 4'h0, 10'h005, 32'h0, 0,  1, 0, 0, 0, 4'h0, 32'h0};
        vecs[3] = '{1, 4'h0, 10'h007, 1, 4'h0, 10'h005, 32'h0, 0,  0, 1, 1, 0, 4'h0, 32'h10000007};
        vecs[4] = '{1, 4'h0, 10'h007, 1, 4'h0, 10'h005, 32'h0, 0,  1, 0, 0, 1, 4'h0, 32'hDEADBEEF};
        vecs[5] = '{1, 4'h0, 10'h007, 1, 4'h0, 10'h005, 32'h0, 0,  0, 1, 1, 0, 4'h0, 32'h10000007};
        vecs[6] = '{0, 4'h0, 10'h000, 1, 4'h2, 10'h3FF, 32'h0000AB00, 0, 0, 1, 0, 1, 4'h2, 32'hDEADBEEF};
        vecs[7] = '{0, 4'h0, 10'h000, 1, 4'h0, 10'h3FF, 32'h0, 0,  0, 1, 0, 0, 4'h0, 32'h0};
        vecs[8] = '{0, 4'h0, 10'h000, 0, 4'h0, 10'h000, 32'h0, 0,  0, 0, 0, 1, 4'h0, 32'h1122AB44};

        for (int i = 0; i < 1024; i++) mem[i] <= 32'h10000000 + i;
        mem[10'h005] <= 32'hDEADBEEF;
        mem[10'h3FF] <= 32'h11223344;

        // Reset with a pending write request: no grant, no RAM write.
        idle_inputs();
        rstn = 0;
        m0_req = 1; m0_we = 4'hF; m0_addr = 10'h005; m0_wdata = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_g0", m0_gnt, 0);
        chk("rst_g1", m1_gnt, 0);
        chk("rst_rv0", m0_rvalid, 0);
        chk("rst_rv1", m1_rvalid, 0);
        chk("rst_abort", lock_abort, 0);
        chk("rst_wea", ram_wea, 0);
        @(negedge clk);
        idle_inputs();
        rstn = 1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we; m0_addr = vecs[i].m0_addr;
            m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr;
            m1_wdata = vecs[i].m1_wdata; m1_lock = vecs[i].m1_lock;
            #1;
            chk($sformatf("v%0d_g0", i), m0_gnt, vecs[i].e_g0);
            chk($sformatf("v%0d_g1", i), m1_gnt, vecs[i].e_g1);
            chk($sformatf("v%0d_rv0", i), m0_rvalid, vecs[i].e_rv0);
            chk($sformatf("v%0d_rv1", i), m1_rvalid, vecs[i].e_rv1);
            chk($sformatf("v%0d_wea", i), ram_wea, vecs[i].e_wea);
            chk($sformatf("v%0d_abort", i), lock_abort, 0);
            if (vecs[i].e_rv0) chk($sformatf("v%0d_rd0", i), m0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rv1) chk($sformatf("v%0d_rd1", i), m1_rdata, vecs[i].e_rdata);
            if (vecs[i].e_g0) chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].m0_addr);
            if (vecs[i].e_g1) chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].m1_addr);
        end

        // Lock limit: port 0 first from IDLE, then 16 locked port-1 grants, then handover.
        @(negedge clk);
        m0_req = 1; m0_addr = 10'h001; m1_req = 1; m1_addr = 10'h002; m1_lock = 1;
        #1;
        chk("lk_first_g0", m0_gnt, 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            chk($sformatf("lk_%0d_g1", k), m1_gnt, 1);
            chk($sformatf("lk_%0d_abort", k), lock_abort, 0);
        end
        @(negedge clk); #1;
        chk("lk_handover_g0", m0_gnt, 1);
        chk("lk_handover_abort", lock_abort, 0);
        @(negedge clk); #1;
        chk("lk_abort_pulse", lock_abort, 1);
        chk("lk_after_g1", m1_gnt, 1);
        @(negedge clk); #1;
        chk("lk_abort_once", lock_abort, 0);
        @(negedge clk);
        idle_inputs();

        // Request withdrawal while port 1 holds the lock.
        @(negedge clk);
        m1_req = 1; m1_addr = 10'h002; m1_lock = 1;
        #1;
        chk("wd_m1_alone", m1_gnt, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m0_req = 1; m0_we = 4'hF; m0_addr = 10'h009; m0_wdata = 32'hBAD0BAD0;
            #1;
            chk($sformatf("wd_%0d_no_g0", k), m0_gnt, 0);
            chk($sformatf("wd_%0d_wea", k), ram_wea, 0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m0_req = 0; m0_we = 0; m0_wdata = 0;
            #1;
            chk($sformatf("wd_drop_%0d_g1", k), m1_gnt, 1);
        end
        chk("wd_mem_untouched", mem[10'h009], 32'h10000009);
        @(negedge clk);
        m0_req = 1; m0_addr = 10'h008;
        n_m1 = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (m0_gnt) begin
                got = 1;
                break;
            end
            if (m1_gnt) n_m1++;
            @(negedge clk);
        end
        chk("wd_m0_granted", got, 1);
        chk("wd_full_lock_after_clear", n_m1, 16);
        @(negedge clk); #1;
        chk("wd_abort_pulse", lock_abort, 1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Reset lands right after a granted read: its return is dropped.
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 10'h005;
        #1;
        chk("rm_g0", m0_gnt, 1);
        #2 rstn = 0;
        @(negedge clk);
        m0_we = 4'hF;
        #1;
        chk("rm_no_rvalid", m0_rvalid, 0);
        chk("rm_gnt_in_reset", m0_gnt, 0);
        chk("rm_wea_in_reset", ram_wea, 0);
        @(negedge clk);
        rstn = 1;
        m0_we = 0; m0_addr = 10'h005;
        m1_req = 1; m1_we = 0; m1_addr = 10'h007;
        #1;
        chk("rm_resume_g0", m0_gnt, 1);
        @(negedge clk); #1;
        chk("rm_resume_g1", m1_gnt, 1);
        chk("rm_resume_rv0", m0_rvalid, 1);
        chk("rm_resume_rd0", m0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter sharing the single-port data RAM between the CPU memory bus (port 0) and a second master such as a program loader or debug engine (port 1). Grants at most one access per clock, with round-robin fairness, an optional bounded burst lock for port 1, and a one-cycle-delayed read-return path. It sits between the bus/controller logic and the RAM macro, which has one-cycle read latency and byte write enables.

## Interface
- `ADDR_W`, default 10: RAM word-address width.
- `DATA_W`, default 32: data width; the byte-enable width is `DATA_W/8`.
- `MAX_LOCK`, default 16: maximum consecutive port-1 grants while `m1_lock` is held and port 0 is waiting.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rstn`  in  1: synchronous, active-low reset.
- `m0_req`, `m1_req`  in  1: access request; held until granted.
- `m0_we`, `m1_we`  in  DATA_W/8: byte write enables; all zero means read.
- `m0_addr`, `m1_addr`  in  ADDR_W: word address.
- `m0_wdata`, `m1_wdata`  in  DATA_W: write data.
- `m1_lock`  in  1: port 1 requests back-to-back ownership.
- `m0_gnt`, `m1_gnt`  out  1: access accepted this cycle; combinational.
- `m0_rvalid`, `m1_rvalid`  out  1: read data valid; registered.
- `m0_rdata`, `m1_rdata`  out  DATA_W: read data, valid only with the matching `rvalid`.
- `ram_addr`  out  ADDR_W, `ram_dina`  out  DATA_W, `ram_wea`  out  DATA_W/8: RAM command.
- `ram_douta`  in  DATA_W: RAM read data, one cycle after the address.
- `lock_abort`  out  1: pulses for one cycle when the lock limit forces a handover.

## Operation
- State machine with states `IDLE`, `OWN0`, `OWN1` (last winner), plus a lock counter `lcnt` of width clog2(MAX_LOCK+1).
- **Arbitration, combinational each cycle:**
  - Only one port requesting: that port wins.
  - Both ports requesting, state `OWN1`, `m1_lock`=1 and `lcnt`<MAX_LOCK: port 1 wins.
  - Both ports requesting, otherwise: the port that did not win last wins. From `IDLE`, port 0 wins.
- The winning port's `gnt`=1 and its addr, wdata and we drive the RAM. With no winner, `ram_wea`=0 and `ram_addr`/`ram_dina` hold their last driven values (don't-care).
- **State update:** the winner sets the state to `OWN0` or `OWN1`. With no request, the state goes to `IDLE`.
- **`lcnt`:**
  - Increments on each port-1 grant while `m1_lock`=1 and `m0_req`=1.
  - Clears on any port-0 grant, on `m1_lock`=0, or on `IDLE`.
  - Saturates at MAX_LOCK.
- **Lock abort:** when port 0 wins because `lcnt`==MAX_LOCK with `m1_lock`=1, `lock_abort` pulses the next cycle.
- **Read return:** a granted read (we==0) sets the granting port's `rvalid` in the next cycle, with `rdata`=`ram_douta`. Granted writes produce no `rvalid`. Each port has at most one read outstanding per cycle, so reads pipeline at full rate.
- **Reset** (`rstn`=0 at a rising edge):
  - state=`IDLE`, `lcnt`=0, both `rvalid`=0, `lock_abort`=0.
  - While `rstn`=0, both `gnt`=0 and `ram_wea`=0 combinationally.
  - A read granted in the cycle before reset is dropped; its `rvalid` is not asserted.

## Timing
- Grant latency is 0 cycles when uncontended; worst case for port 0 is MAX_LOCK cycles under port-1 lock.
- Read: `gnt` at cycle N; `rvalid`/`rdata` at cycle N+1.
- Write: committed at the rising edge ending cycle N. A read of the same address at N+1 returns the new data.
- Requesters must hold req, addr, we and wdata stable until `gnt`. Deasserting `req` before `gnt` is allowed and cancels the request with no side effects.
- Simultaneous requests alternate every cycle when neither port is locked.

## Structure
- A shared package holds:
  - the state enum {`IDLE`, `OWN0`, `OWN1`};
  - the `rd_ret_t` record {valid, port};
  - the `MAX_LOCK` default constant.
- Sub-module `rr_pick2`: combinational 2-way round-robin selector. Inputs are req[1:0], last and force1; outputs are gnt[1:0]. `dram_arbiter` holds all registers.

## Test plan
- **Solo read:** `m0_req`=1, we=0, addr=0x005 with RAM[5]=0xDEADBEEF -> `m0_gnt`=1 the same cycle; `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF the next cycle; `m1_rvalid` stays 0.
- **Contention, no lock:** both ports request continuously -> grants alternate 0,1,0,1,… starting with port 0 from `IDLE`.
- **Byte write then read:** port 1 writes we=4'b0010, wdata=0x0000AB00 to addr 0x3FF holding 0x11223344, then reads it -> `m1_rdata`=0x1122AB44.
- **Lock limit:** `m1_lock`=1 with both ports requesting, MAX_LOCK=16 -> 16 consecutive `m1_gnt` after the first port-0 loss, then `m0_gnt`=1 and `lock_abort` pulses once in the next cycle.
- **Reset mid-read:** port-0 read granted at cycle N with `rstn`=0 sampled at the end of N -> no `m0_rvalid` at N+1; `gnt`=0 while in reset; arbitration resumes from `IDLE` with port 0 first.
- **Request withdrawal:** `m0_req` pulses while port 1 is locked and is dropped before grant -> no `m0_gnt`, no RAM write, and `lcnt` clears when `m0_req` falls.
